// File: rtl/ctrl_fsm_pkg.sv
// ctrl_fsm_pkg: shared encodings for the multicycle controller and its datapath
package ctrl_fsm_pkg;
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  typedef enum logic [3:0] {
    C_ILL, C_R, C_JR, C_LW, C_SW, C_BEQ, C_BNE, C_ADDI, C_ORI, C_LUI, C_J, C_JAL
  } iclass_t;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4;
  localparam logic AA_PC = 1'b0, AA_REG = 1'b1;
  localparam logic [2:0] AB_REG = 3'd0, AB_FOUR = 3'd1, AB_SEXT = 3'd2, AB_SEXT2 = 3'd3, AB_ZEXT = 3'd4;
  localparam logic [2:0] PC_INC = 3'd0, PC_BR = 3'd1, PC_JUMP = 3'd2, PC_REG = 3'd3;
  localparam logic [2:0] WB_ALU = 3'd0, WB_MDR = 3'd1, WB_PC = 3'd2, WB_LUI = 3'd3;
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_31 = 2'b10;
  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    return f == FN_SUB ? ALU_SUB : f == FN_AND ? ALU_AND : f == FN_OR ? ALU_OR :
           f == FN_SLT ? ALU_SLT : ALU_ADD;
  endfunction
endpackage

// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm_if: instruction fields in, datapath controls out
interface ctrl_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic zero;
  logic pc_we;
  logic ir_we;
  logic mem_we;
  logic rf_we;
  logic alua_sel;
  logic [2:0] alub_sel;
  logic [2:0] pc_sel;
  logic [2:0] wb_sel;
  logic [1:0] reg_dst;
  logic [2:0] alu_op;
  logic [2:0] state;
  logic instr_done;
  logic [31:0] instr_cnt;
  modport master(
    input opcode, funct, zero,
    output pc_we, ir_we, mem_we, rf_we, alua_sel, alub_sel, pc_sel, wb_sel, reg_dst, alu_op,
    output state, instr_done, instr_cnt
  );
  modport slave(
    output opcode, funct, zero,
    input pc_we, ir_we, mem_we, rf_we, alua_sel, alub_sel, pc_sel, wb_sel, reg_dst, alu_op,
    input state, instr_done, instr_cnt
  );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction-class and R-type ALU op decode
module ctrl_decode
  import ctrl_fsm_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls,
  output logic [2:0] r_op
);
  iclass_t r_cls;
  assign r_cls = funct == FN_JR ? C_JR :
                 funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT} ? C_R : C_ILL;
  assign r_op = funct_alu(funct);
  always_comb begin
    cls = C_ILL;
    case (opcode)
      OP_R:    cls = r_cls;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_BNE:  cls = C_BNE;
      OP_ADDI: cls = C_ADDI;
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILL;
    endcase
  end
endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multicycle MIPS-subset controller with retired-instruction counter
module ctrl_fsm
  import ctrl_fsm_pkg::*;
(
  input logic       clk,
  input logic       rst,
  ctrl_fsm_if.master bus
);
  logic [2:0] state_q;
  state_t nxt;
  logic [31:0] cnt_q;
  iclass_t cls;
  logic [2:0] r_op;
  ctrl_decode u_dec (.opcode(bus.opcode), .funct(bus.funct), .cls(cls), .r_op(r_op));
  always_ff @(posedge clk) begin
    state_q <= rst ? S_IF : nxt;
    cnt_q   <= rst ? 32'd0 : cnt_q + {31'd0, bus.instr_done};
  end
  assign bus.state = state_q;
  assign bus.instr_cnt = cnt_q;
  always_comb begin
    nxt = S_IF;
    bus.pc_we = 1'b0;
    bus.ir_we = 1'b0;
    bus.mem_we = 1'b0;
    bus.rf_we = 1'b0;
    bus.alua_sel = AA_PC;
    bus.alub_sel = AB_REG;
    bus.pc_sel = PC_INC;
    bus.wb_sel = WB_ALU;
    bus.reg_dst = RD_RT;
    bus.alu_op = ALU_ADD;
    bus.instr_done = 1'b0;
    case (state_q)
      S_IF: begin
        bus.ir_we = 1'b1;
        bus.pc_we = 1'b1;
        bus.alub_sel = AB_FOUR;
        nxt = S_ID;
      end
      S_ID: begin
        bus.alub_sel = AB_SEXT2;
        case (cls)
          C_J, C_JAL: begin
            bus.pc_we = 1'b1;
            bus.pc_sel = PC_JUMP;
            bus.instr_done = 1'b1;
          end
          C_JR: begin
            bus.pc_we = 1'b1;
            bus.pc_sel = PC_REG;
            bus.instr_done = 1'b1;
          end
          C_ILL: nxt = S_IF;
          default: nxt = S_EXE;
        endcase
        if (cls == C_JAL) begin
          bus.rf_we = 1'b1;
          bus.reg_dst = RD_31;
          bus.wb_sel = WB_PC;
        end
      end
      S_EXE: begin
        bus.alua_sel = cls == C_LUI ? AA_PC : AA_REG;
        nxt = S_WB;
        case (cls)
          C_BEQ, C_BNE: begin
            bus.alu_op = ALU_SUB;
            bus.pc_sel = PC_BR;
            bus.pc_we = cls == C_BEQ ? bus.zero : ~bus.zero;
            bus.instr_done = 1'b1;
            nxt = S_IF;
          end
          C_LW, C_SW: begin
            bus.alub_sel = AB_SEXT;
            nxt = S_MEM;
          end
          C_ADDI: bus.alub_sel = AB_SEXT;
          C_ORI: begin
            bus.alub_sel = AB_ZEXT;
            bus.alu_op = ALU_OR;
          end
          C_R: bus.alu_op = r_op;
          default: nxt = S_WB;
        endcase
      end
      S_MEM: begin
        bus.mem_we = cls == C_SW;
        bus.instr_done = cls == C_SW;
        nxt = cls == C_LW ? S_WB : S_IF;
      end
      S_WB: begin
        bus.rf_we = 1'b1;
        bus.wb_sel = cls == C_LW ? WB_MDR : cls == C_LUI ? WB_LUI : WB_ALU;
        bus.reg_dst = cls == C_R ? RD_RD : RD_RT;
        bus.instr_done = 1'b1;
      end
      default: nxt = S_IF;
    endcase
    // reset must silence every side effect immediately, not one edge later
    if (rst) begin
      bus.pc_we = 1'b0;
      bus.ir_we = 1'b0;
      bus.mem_we = 1'b0;
      bus.rf_we = 1'b0;
      bus.instr_done = 1'b0;
    end
  end
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: directed per-cycle expectations checked through a scoreboard queue
module tb_ctrl_fsm;
  typedef struct {
    string       n;
    logic [2:0]  st;
    logic [19:0] ctl;
    logic [31:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] ec = 32'd0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  ctrl_fsm_if bus();
  ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  function automatic logic [19:0] c(input logic pcw, irw, mw, rw, aa, input logic [2:0] ab, ps, wb,
                                    input logic [1:0] rd, input logic [2:0] ao, input logic dn);
    return {pcw, irw, mw, rw, aa, ab, ps, wb, rd, ao, dn};
  endfunction
  task automatic cyc(input string n, input logic [2:0] st, input logic [19:0] ctl);
    exp_t e;
    e.n = n;
    e.st = st;
    e.ctl = ctl;
    e.cnt = ec;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input string n, input logic [5:0] op, fn, input logic z);
    bus.opcode = op;
    bus.funct = fn;
    bus.zero = z;
    cyc({n, "_if"}, 3'd0, c(1, 1, 0, 0, 0, 3'd1, 3'd0, 3'd0, 2'd0, 3'd0, 0));
  endtask
  task automatic dec(input string n);
    cyc({n, "_id"}, 3'd1, c(0, 0, 0, 0, 0, 3'd3, 3'd0, 3'd0, 2'd0, 3'd0, 0));
  endtask
  task automatic rtype(input string n, input logic [5:0] fn, input logic [2:0] ao);
    fetch(n, 6'h00, fn, 0);
    dec(n);
    cyc({n, "_exe"}, 3'd2, c(0, 0, 0, 0, 1, 3'd0, 3'd0, 3'd0, 2'd0, ao, 0));
    cyc({n, "_wb"}, 3'd4, c(0, 0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 2'd1, 3'd0, 1));
    ec++;
  endtask
  task automatic br(input string n, input logic [5:0] op, input logic z, input logic pcw);
    fetch(n, op, 6'h00, z);
    dec(n);
    cyc({n, "_exe"}, 3'd2, c(pcw, 0, 0, 0, 1, 3'd0, 3'd1, 3'd0, 2'd0, 3'd1, 1));
    ec++;
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [19:0] a;
      e = q.pop_front();
      a = {bus.pc_we, bus.ir_we, bus.mem_we, bus.rf_we, bus.alua_sel, bus.alub_sel, bus.pc_sel,
           bus.wb_sel, bus.reg_dst, bus.alu_op, bus.instr_done};
      checks++;
      if (bus.state !== e.st || a !== e.ctl || bus.instr_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s: got state=%0d ctl=%05h cnt=%08h, want state=%0d ctl=%05h cnt=%08h",
                 e.n, bus.state, a, bus.instr_cnt, e.st, e.ctl, e.cnt);
      end
    end
  end
  initial begin
    bus.opcode = 6'h00;
    bus.funct = 6'h20;
    bus.zero = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", 3'd0, c(0, 0, 0, 0, 0, 3'd1, 3'd0, 3'd0, 2'd0, 3'd0, 0));
    rst = 1'b0;
    rtype("add", 6'h20, 3'd0);
    rtype("slt", 6'h2A, 3'd4);
    rtype("and", 6'h24, 3'd2);
    fetch("lw", 6'h23, 6'h00, 0);
    dec("lw");
    cyc("lw_exe", 3'd2, c(0, 0, 0, 0, 1, 3'd2, 3'd0, 3'd0, 2'd0, 3'd0, 0));
    cyc("lw_mem", 3'd3, c(0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 0));
    cyc("lw_wb", 3'd4, c(0, 0, 0, 1, 0, 3'd0, 3'd0, 3'd1, 2'd0, 3'd0, 1));
    ec++;
    fetch("sw", 6'h2B, 6'h00, 0);
    dec("sw");
    cyc("sw_exe", 3'd2, c(0, 0, 0, 0, 1, 3'd2, 3'd0, 3'd0, 2'd0, 3'd0, 0));
    cyc("sw_mem", 3'd3, c(0, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 1));
    ec++;
    br("beq_z1", 6'h04, 1, 1);
    br("beq_z0", 6'h04, 0, 0);
    br("bne_z0", 6'h05, 0, 1);
    br("bne_z1", 6'h05, 1, 0);
    fetch("ori", 6'h0D, 6'h00, 0);
    dec("ori");
    cyc("ori_exe", 3'd2, c(0, 0, 0, 0, 1, 3'd4, 3'd0, 3'd0, 2'd0, 3'd3, 0));
    cyc("ori_wb", 3'd4, c(0, 0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 1));
    ec++;
    fetch("lui", 6'h0F, 6'h00, 0);
    dec("lui");
    cyc("lui_exe", 3'd2, c(0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 0));
    cyc("lui_wb", 3'd4, c(0, 0, 0, 1, 0, 3'd0, 3'd0, 3'd3, 2'd0, 3'd0, 1));
    ec++;
    fetch("jal", 6'h03, 6'h00, 0);
    cyc("jal_id", 3'd1, c(1, 0, 0, 1, 0, 3'd3, 3'd2, 3'd2, 2'd2, 3'd0, 1));
    ec++;
    fetch("j", 6'h02, 6'h00, 0);
    cyc("j_id", 3'd1, c(1, 0, 0, 0, 0, 3'd3, 3'd2, 3'd0, 2'd0, 3'd0, 1));
    ec++;
    fetch("jr", 6'h00, 6'h08, 0);
    cyc("jr_id", 3'd1, c(1, 0, 0, 0, 0, 3'd3, 3'd3, 3'd0, 2'd0, 3'd0, 1));
    ec++;
    fetch("ill_op", 6'h3F, 6'h00, 0);
    dec("ill_op");
    fetch("ill_fn", 6'h00, 6'h3F, 0);
    dec("ill_fn");
    fetch("swr", 6'h2B, 6'h00, 0);
    dec("swr");
    cyc("swr_exe", 3'd2, c(0, 0, 0, 0, 1, 3'd2, 3'd0, 3'd0, 2'd0, 3'd0, 0));
    rst = 1'b1;
    cyc("swr_mem_rst", 3'd3, c(0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 0));
    rst = 1'b0;
    ec = 32'd0;
    fetch("post_rst", 6'h3F, 6'h00, 0);
    dec("post_rst");
    dut.cnt_q <= 32'hFFFF_FFFF;
    ec = 32'hFFFF_FFFF;
    fetch("wrap_j", 6'h02, 6'h00, 0);
    cyc("wrap_j_id", 3'd1, c(1, 0, 0, 0, 0, 3'd3, 3'd2, 3'd0, 2'd0, 3'd0, 1));
    ec++;
    fetch("wrap_jal", 6'h03, 6'h00, 0);
    cyc("wrap_jal_id", 3'd1, c(1, 0, 0, 1, 0, 3'd3, 3'd2, 3'd2, 2'd2, 3'd0, 1));
    ec++;
    fetch("wrap_end", 6'h00, 6'h20, 0);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 The block SHALL have these ports, each with name, direction, width and meaning:
 clk  in  1  single clock; all state updates on its rising edge
 rst  in  1  synchronous, active-high reset
 opcode  in  6  IR[31:26]
 funct  in  6  IR[5:0]
 zero  in  1  ALU zero flag, combinational in the same cycle
 pc_we  out  1  PC write enable
 ir_we  out  1  instruction-register write enable
 mem_we  out  1  data-memory write enable
 rf_we  out  1  register-file write enable
 alua_sel  out  1  ALU A source: 0 = PC, 1 = A register
 alub_sel  out  3  ALU B source, drives a mux8
 pc_sel  out  3  next-PC source, drives a mux8
 wb_sel  out  3  register write-back source, drives a mux8
 reg_dst  out  2  destination register: 00 = rt, 01 = rd, 10 = $31
 alu_op  out  3  ALU operation
 state  out  3  current state, for debug
 instr_done  out  1  one-cycle pulse when an instruction retires
 instr_cnt  out  32  count of retired instructions
REQ-002 Parameters: none.

Function
REQ-003 The block SHALL use these states: IF=0, ID=1, EXE=2, MEM=3, WB=4; the encodings 5-7 SHALL go to IF on the next edge with all enables low.
REQ-004 Supported instructions SHALL be R-type (add, sub, and, or, slt, jr), lw, sw, beq, bne, addi, ori, lui, j and jal; any other opcode or funct is illegal.
REQ-005 IF SHALL assert ir_we=1 and pc_we=1, with alua_sel=0, alub_sel=001 (const 4), alu_op=add and pc_sel=000; the next state SHALL be ID.
REQ-006 ID SHALL compute the branch target into ALUOut using alua_sel=0, alub_sel=011 (sext<<2) and alu_op=add.
REQ-007 From ID: j SHALL take pc_we=1, pc_sel=010 and go to IF; jal SHALL do the same plus rf_we=1, reg_dst=10 and wb_sel=010; jr SHALL take pc_we=1, pc_sel=011 and go to IF; an illegal instruction SHALL go to IF with no writes; all others SHALL go to EXE.
REQ-008 EXE for beq/bne SHALL drive alua_sel=1, alub_sel=000 and alu_op=sub; pc_we SHALL equal (beq&zero)|(bne&~zero), with pc_sel=001; the next state SHALL be IF.
REQ-009 EXE for lw/sw/addi SHALL use alub_sel=010 (sext imm) with add; for ori it SHALL use 100 (zext imm) with or; for lui it SHALL use no ALU operation (don't-care); for R-type it SHALL use alub_sel=000 with alu_op from funct.
REQ-010 From EXE: lw/sw SHALL go to MEM; all other instructions SHALL go to WB.
REQ-011 MEM for sw SHALL assert mem_we=1 and go to IF; for lw it SHALL go to WB.
REQ-012 WB SHALL assert rf_we=1 and go to IF; wb_sel SHALL be 001 (MDR) for lw, 011 (imm<<16) for lui, and 000 (ALUOut) otherwise; reg_dst SHALL be 01 for R-type and 00 otherwise.
REQ-013 alu_op encodings SHALL be add=000, sub=001, and=010, or=011, slt=100.
REQ-014 Select outputs SHALL never carry codes 101-111; in cycles where a select is unused it SHALL be 000.
REQ-015 instr_done SHALL pulse in the last cycle of every legal instruction (the cycle whose next state is IF); it SHALL NOT pulse for an illegal instruction.
REQ-016 instr_cnt SHALL increment by 1 on each instr_done and wrap from 0xFFFFFFFF to 0.
REQ-017 All outputs except state and instr_cnt SHALL be combinational from state, opcode, funct and zero.

Reset
REQ-018 While rst=1: state SHALL become IF and instr_cnt SHALL become 0 on the next edge, and all write enables and instr_done SHALL be forced to 0 combinationally.
REQ-019 rst asserted mid-instruction SHALL abandon that instruction with no further writes and without counting it.
REQ-020 The first IF fetch SHALL occur in the first cycle with rst=0.

Structure
REQ-021 State encodings, opcode/funct constants, alu_op codes and mux-select codes SHALL be defined in a shared package, also used by the datapath.
REQ-022 One sub-module, ctrl_decode (purely combinational instruction-class decode), SHALL be used; the FSM and counter SHALL stay in ctrl_fsm.

Verification
REQ-023 add $3,$1,$2: the bench SHALL observe states IF,ID,EXE,WB; WB with rf_we=1, reg_dst=01 and wb_sel=000; instr_cnt going 0->1.
REQ-024 lw: 5 cycles with MEM mem_we=0 and WB wb_sel=001; sw: 4 cycles with mem_we=1 only in MEM; instr_cnt=2 after both.
REQ-025 beq with zero=1 SHALL give pc_we=1 and pc_sel=001 in EXE; beq with zero=0 SHALL give pc_we=0; bne SHALL give the inverse.
REQ-026 jal SHALL take 2 cycles and give, in ID, pc_we=1, pc_sel=010, rf_we=1, reg_dst=10 and wb_sel=010; j SHALL give rf_we=0.
REQ-027 opcode 0x3F SHALL give IF,ID,IF with no write enable, instr_done=0 and instr_cnt unchanged.
REQ-028 rst pulsed during MEM of an sw SHALL give mem_we=0, state IF and instr_cnt=0; with instr_cnt preset near 0xFFFFFFFF, two retirements SHALL make it wrap to 1.
